stack_tos_param: RTL and testbench

STACK_TOS_PARAM -- requirements
Module: stack_tos_param

---
 rtl/stack_tos_param.sv | 186 ++++++++++++++++++
 tb/tb_stack_tos_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/stack_tos_param.sv
// stack_tos_param: LIFO stack with registered top-of-stack / next-on-stack
// views, single-cycle operations and sticky overflow/underflow flags.
//
// Ports
//   clk_i             clock, all state changes on the rising edge
//   reset_i           synchronous active-high reset (wins over any operation)
//   op_valid_i        apply op_i on this edge
//   op_i              0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 POP2_PUSH,
//                     6 REPLACE, 7 CLEAR
//   data_i            operand for PUSH, POP2_PUSH, REPLACE
//   clr_err_i         clears sticky error flags (a same-cycle new error wins)
//   tos_o / nos_o     top / next entry, 0 when not present
//   count_o           number of valid entries
//   empty_o / full_o  count_o==0 / count_o==DEPTH
//   done_o            one-cycle pulse after each accepted legal operation
//   err_overflow_o / err_underflow_o  sticky error flags
module stack_tos_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  op_valid_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] tos_o,
    output logic [DATA_WIDTH-1:0] nos_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  done_o,
    output logic                  err_overflow_o,
    output logic                  err_underflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_PUSH      = 3'd1;
    localparam logic [2:0] OP_POP       = 3'd2;
    localparam logic [2:0] OP_DUP       = 3'd3;
    localparam logic [2:0] OP_SWAP      = 3'd4;
    localparam logic [2:0] OP_POP2_PUSH = 3'd5;
    localparam logic [2:0] OP_REPLACE   = 3'd6;
    localparam logic [2:0] OP_CLEAR     = 3'd7;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
    logic                  empty_q, full_q, done_q, done_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    logic                  is_empty, is_full, lt2;
    logic                  set_ovf, set_unf;
    logic [AW-1:0]         wr_idx, top_idx, nos_idx, rd_top, rd_nos;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);
    assign lt2      = (count_q < CNT_TWO);

    // Write slot and current top/next slots; only used when the op is legal,
    // so the wrap of these indices at the boundaries never matters.
    assign wr_idx  = AW'(count_q);
    assign top_idx = AW'(count_q - CNT_ONE);
    assign nos_idx = AW'(count_q - CNT_TWO);

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        done_d  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (op_valid_i) begin
            unique case (op_i)
                OP_NOP: ;
                OP_PUSH: begin
                    if (is_full) set_ovf = 1'b1;
                    else begin
                        mem_d[wr_idx] = data_i;
                        count_d = count_q + CNT_ONE;
                        done_d  = 1'b1;
                    end
                end
                OP_POP: begin
                    if (is_empty) set_unf = 1'b1;
                    else begin
                        count_d = count_q - CNT_ONE;
                        done_d  = 1'b1;
                    end
                end
                OP_DUP: begin
                    if (is_full) set_ovf = 1'b1;
                    else if (is_empty) set_unf = 1'b1;
                    else begin
                        mem_d[wr_idx] = mem_q[top_idx];
                        count_d = count_q + CNT_ONE;
                        done_d  = 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (lt2) set_unf = 1'b1;
                    else begin
                        mem_d[top_idx] = mem_q[nos_idx];
                        mem_d[nos_idx] = mem_q[top_idx];
                        done_d = 1'b1;
                    end
                end
                OP_POP2_PUSH: begin
                    // Result lands in the old NOS slot, which becomes the new top.
                    if (lt2) set_unf = 1'b1;
                    else begin
                        mem_d[nos_idx] = data_i;
                        count_d = count_q - CNT_ONE;
                        done_d  = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (is_empty) set_unf = 1'b1;
                    else begin
                        mem_d[top_idx] = data_i;
                        done_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    count_d = '0;
                    done_d  = 1'b1;
                end
                default: ;
            endcase
        end

        // Set wins over a same-cycle clear.
        ovf_d = (ovf_q & ~clr_err_i) | set_ovf;
        unf_d = (unf_q & ~clr_err_i) | set_unf;

        // Registered views are taken from the post-operation image.
        rd_top = AW'(count_d - CNT_ONE);
        rd_nos = AW'(count_d - CNT_TWO);
        tos_d  = (count_d >= CNT_ONE) ? mem_d[rd_top] : '0;
        nos_d  = (count_d >= CNT_TWO) ? mem_d[rd_nos] : '0;
    end

    // Entry storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_FULL);
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tos_o           = tos_q;
    assign nos_o           = nos_q;
    assign count_o         = count_q;
    assign empty_o         = empty_q;
    assign full_o          = full_q;
    assign done_o          = done_q;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

endmodule

// File: tb/tb_stack_tos_param.sv
// Bench for stack_tos_param (DEPTH=4 so full/empty boundaries are hit often):
// directed sequences plus a random run, compared every cycle against a
// queue-based reference stack.
module tb_stack_tos_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          op_valid_i = 1'b0;
    logic [2:0]    op_i = 3'd0;
    logic [DW-1:0] data_i = '0;
    logic          clr_err_i = 1'b0;
    logic [DW-1:0] tos_o, nos_o;
    logic [CW-1:0] count_o;
    logic          empty_o, full_o, done_o, err_overflow_o, err_underflow_o;

    stack_tos_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .op_valid_i(op_valid_i), .op_i(op_i),
        .data_i(data_i), .clr_err_i(clr_err_i), .tos_o(tos_o), .nos_o(nos_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .done_o(done_o),
        .err_overflow_o(err_overflow_o), .err_underflow_o(err_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [DW-1:0] stk[$];
    logic m_ovf = 1'b0, m_unf = 1'b0, m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic v, input logic [2:0] op,
                         input logic [DW-1:0] d, input logic clr);
        int n;
        logic so, su;
        logic [DW-1:0] tmp;
        n = stk.size();
        so = 1'b0; su = 1'b0;
        if (rst) begin
            stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (v) begin
            case (op)
                3'd1: if (n == DEPTH) so = 1; else begin stk.push_back(d); m_done = 1; end
                3'd2: if (n == 0) su = 1; else begin void'(stk.pop_back()); m_done = 1; end
                3'd3: if (n == DEPTH) so = 1; else if (n == 0) su = 1;
                      else begin stk.push_back(stk[n-1]); m_done = 1; end
                3'd4: if (n < 2) su = 1;
                      else begin tmp = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = tmp; m_done = 1; end
                3'd5: if (n < 2) su = 1;
                      else begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(d); m_done = 1; end
                3'd6: if (n == 0) su = 1; else begin stk[n-1] = d; m_done = 1; end
                3'd7: begin stk.delete(); m_done = 1; end
                default: ;
            endcase
        end
        m_ovf = (m_ovf & ~clr) | so;
        m_unf = (m_unf & ~clr) | su;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = stk.size();
        chk({tag, ".tos"},   32'(tos_o),   (n >= 1) ? 32'(stk[n-1]) : 32'd0);
        chk({tag, ".nos"},   32'(nos_o),   (n >= 2) ? 32'(stk[n-2]) : 32'd0);
        chk({tag, ".count"}, 32'(count_o), 32'(n));
        chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
        chk({tag, ".full"},  32'(full_o),  32'(n == DEPTH));
        chk({tag, ".done"},  32'(done_o),  32'(m_done));
        chk({tag, ".ovf"},   32'(err_overflow_o),  32'(m_ovf));
        chk({tag, ".unf"},   32'(err_underflow_o), 32'(m_unf));
    endtask

    // Drive one cycle, advance the model, sample after the edge.
    task automatic step(input string tag, input logic rst, input logic v, input logic [2:0] op,
                        input logic [DW-1:0] d, input logic clr);
        reset_i = rst; op_valid_i = v; op_i = op; data_i = d; clr_err_i = clr;
        model(rst, v, op, d, clr);
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        @(negedge clk_i);
        step("reset", 1, 0, 0, 0, 0);

        // Two pushes, swap, binary op
        step("push11", 0, 1, 3'd1, 8'h11, 0);
        step("push22", 0, 1, 3'd1, 8'h22, 0);
        chk("d036.tos", 32'(tos_o), 32'h22);
        chk("d036.nos", 32'(nos_o), 32'h11);
        step("swap", 0, 1, 3'd4, 8'h00, 0);
        chk("d037.tos", 32'(tos_o), 32'h11);
        step("pop2push", 0, 1, 3'd5, 8'h33, 0);
        chk("d037.tos2", 32'(tos_o), 32'h33);
        chk("d037.cnt", 32'(count_o), 32'd1);

        // Overflow at DEPTH=4
        step("rst2", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step("ovfpush", 0, 1, 3'd1, DW'(i), 0);
        chk("d038.tos", 32'(tos_o), 32'd4);
        chk("d038.ovf", 32'(err_overflow_o), 32'd1);
        step("dupfull", 0, 1, 3'd3, 8'h00, 0);
        step("replace", 0, 1, 3'd6, 8'hA5, 0);
        step("nop", 0, 1, 3'd0, 8'h00, 0);
        step("idle", 0, 0, 3'd2, 8'h00, 0);

        // Underflow and sticky clear behaviour
        step("clear", 0, 1, 3'd7, 8'h00, 0);
        step("popempty", 0, 1, 3'd2, 8'h00, 0);
        step("swapempty", 0, 1, 3'd4, 8'h00, 0);
        step("dupempty", 0, 1, 3'd3, 8'h00, 0);
        step("clr+pop", 0, 1, 3'd2, 8'h00, 1);
        chk("d039.unf", 32'(err_underflow_o), 32'd1);
        step("clronly", 0, 0, 3'd0, 8'h00, 1);
        chk("d039.unf0", 32'(err_underflow_o), 32'd0);

        // Reset wins over a same-cycle push
        for (int i = 0; i < 3; i++) step("fill3", 0, 1, 3'd1, DW'(8'h40 + i), 0);
        step("rst+push", 1, 1, 3'd1, 8'h77, 0);
        chk("d040.cnt", 32'(count_o), 32'd0);
        chk("d040.tos", 32'(tos_o), 32'd0);

        // Random back-to-back operations
        for (int i = 0; i < 1000; i++) begin
            step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                 3'($urandom_range(0, 7)), DW'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
